// File: rtl/fxp_convert_pipe.sv
// Multi-channel signed fixed-point format converter: align/round, then saturate/wrap,
// two register stages with valid/ready flow and sticky per-channel overflow reporting.
module fxp_convert_pipe #(
  parameter int unsigned N_INT_IN   = 8,
  parameter int unsigned N_MANT_IN  = 23,
  parameter int unsigned N_INT_OUT  = 8,
  parameter int unsigned N_MANT_OUT = 23,
  parameter int unsigned N_CH       = 1,
  parameter int unsigned ROUND_MODE = 1,
  parameter int unsigned SATURATE   = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                                      clk,
  input  logic                                      rstn,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [N_CH*(N_INT_IN+N_MANT_IN+1)-1:0]    in_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [N_CH*(N_INT_OUT+N_MANT_OUT+1)-1:0]  out_data,
  output logic [N_CH-1:0]                           ovf_flag,
  output logic [CNT_W-1:0]                          ovf_count,
  input  logic                                      ovf_clear
);

  localparam int unsigned W_IN  = N_INT_IN + N_MANT_IN + 1;
  localparam int unsigned W_OUT = N_INT_OUT + N_MANT_OUT + 1;
  localparam int          D     = int'(N_MANT_IN) - int'(N_MANT_OUT);
  localparam int unsigned SHL   = (D < 0) ? -D : 0;
  localparam int unsigned SHR   = (D > 0) ? D : 0;
  // Internal width leaves headroom for the rounding carry and for left alignment.
  localparam int unsigned WI    = W_IN + 2 + SHL;
  localparam int unsigned WC    = ((WI > W_OUT) ? WI : W_OUT) + 1;
  localparam logic signed [WC-1:0] MAX_V = (WC'(1) << (W_OUT - 1)) - WC'(1);
  localparam logic signed [WC-1:0] MIN_V = -(WC'(1) << (W_OUT - 1));

  logic                           v1;
  logic                           rdy1;
  logic                           rdy2;
  logic                           s2_fire;
  logic                           any_ovf;
  logic [N_CH-1:0][WI-1:0]        s1_d;
  logic [N_CH-1:0][WI-1:0]        s1_q;
  logic [N_CH-1:0][W_OUT-1:0]     s2_d;
  logic [N_CH-1:0]                ovf_d;

  assign rdy2     = !out_valid || out_ready;
  assign rdy1     = !v1 || rdy2;
  assign in_ready = rdy1;
  assign s2_fire  = v1 && rdy2;
  assign any_ovf  = s2_fire && (|ovf_d);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic signed [W_IN-1:0] x;
    logic signed [WC-1:0]   v;
    logic [W_OUT-1:0]       r;

    assign x = in_data[k*W_IN +: W_IN];

    if (D > 0) begin : g_rnd
      logic signed [WI-1:0] ext;
      logic signed [WI-1:0] sum;
      logic signed [WI-1:0] shr;
      logic [SHR-1:0]       half;
      always_comb begin
        half          = '0;
        half[SHR-1]   = 1'b1;
        ext           = WI'(x);
        sum           = (ROUND_MODE == 0) ? ext : ext + (WI'(1) << (SHR - 1));
        shr           = sum >>> SHR;
        // Convergent: an exact tie always lands on the even neighbour.
        if (ROUND_MODE == 2 && x[SHR-1:0] == half) shr[0] = 1'b0;
      end
      assign s1_d[k] = shr;
    end else begin : g_shl
      assign s1_d[k] = WI'(x) <<< SHL;
    end

    assign v = WC'($signed(s1_q[k]));
    assign ovf_d[k] = (v > MAX_V) || (v < MIN_V);

    always_comb begin
      r = v[W_OUT-1:0];
      if (SATURATE != 0) begin
        if (v > MAX_V)      r = MAX_V[W_OUT-1:0];
        else if (v < MIN_V) r = MIN_V[W_OUT-1:0];
      end
    end
    assign s2_d[k] = r;
  end

  // Two-stage pipeline; each stage holds while the next one is stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1        <= 1'b0;
      out_valid <= 1'b0;
      s1_q      <= '0;
      out_data  <= '0;
    end else begin
      if (rdy1)              v1        <= in_valid;
      if (in_valid && rdy1)  s1_q      <= s1_d;
      if (rdy2)              out_valid <= v1;
      if (s2_fire)           out_data  <= s2_d;
    end
  end

  // Overflow status; a clear in the same cycle as an overflow beat keeps that beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_flag  <= '0;
      ovf_count <= '0;
    end else if (ovf_clear) begin
      ovf_flag  <= s2_fire ? ovf_d : '0;
      ovf_count <= any_ovf ? CNT_W'(1) : '0;
    end else begin
      if (s2_fire) ovf_flag <= ovf_flag | ovf_d;
      if (any_ovf && ovf_count != '1) ovf_count <= ovf_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fxp_convert_pipe.sv
// Directed bench for fxp_convert_pipe: several parameter variants share one stimulus
// stream; each scenario task checks the variant it targets against hand-derived values.
module tb_fxp_convert_pipe;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        ovf_clear = 1'b0;
  logic [15:0] in_data = '0;

  logic rdy_m0, rdy_m1, rdy_m2, rdy_s1, rdy_s0, rdy_w, rdy_c2;
  logic ov_m0, ov_m1, ov_m2, ov_s1, ov_s0, ov_w, ov_c2;
  logic [11:0] d_m0, d_m1, d_m2;
  logic [7:0]  d_s1, d_s0, d_c2;
  logic [23:0] d_w;
  logic [1:0]  fl_m0, fl_m1, fl_m2, fl_s1, fl_s0, fl_w, fl_c2;
  logic [15:0] cnt_m0, cnt_m1, cnt_m2, cnt_s1, cnt_s0, cnt_w;
  logic [1:0]  cnt_c2;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  // Q3.4 -> Q3.2, one instance per rounding mode
  fxp_convert_pipe #(.N_INT_IN(3), .N_MANT_IN(4), .N_INT_OUT(3), .N_MANT_OUT(2), .N_CH(2),
    .ROUND_MODE(0), .SATURATE(1), .CNT_W(16)) u_m0 (.clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(rdy_m0), .in_data(in_data), .out_valid(ov_m0),
    .out_ready(out_ready), .out_data(d_m0), .ovf_flag(fl_m0), .ovf_count(cnt_m0),
    .ovf_clear(ovf_clear));
  fxp_convert_pipe #(.N_INT_IN(3), .N_MANT_IN(4), .N_INT_OUT(3), .N_MANT_OUT(2), .N_CH(2),
    .ROUND_MODE(1), .SATURATE(1), .CNT_W(16)) u_m1 (.clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(rdy_m1), .in_data(in_data), .out_valid(ov_m1),
    .out_ready(out_ready), .out_data(d_m1), .ovf_flag(fl_m1), .ovf_count(cnt_m1),
    .ovf_clear(ovf_clear));
  fxp_convert_pipe #(.N_INT_IN(3), .N_MANT_IN(4), .N_INT_OUT(3), .N_MANT_OUT(2), .N_CH(2),
    .ROUND_MODE(2), .SATURATE(1), .CNT_W(16)) u_m2 (.clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(rdy_m2), .in_data(in_data), .out_valid(ov_m2),
    .out_ready(out_ready), .out_data(d_m2), .ovf_flag(fl_m2), .ovf_count(cnt_m2),
    .ovf_clear(ovf_clear));
  // Q3.4 -> Q1.2, saturating and wrapping
  fxp_convert_pipe #(.N_INT_IN(3), .N_MANT_IN(4), .N_INT_OUT(1), .N_MANT_OUT(2), .N_CH(2),
    .ROUND_MODE(1), .SATURATE(1), .CNT_W(16)) u_s1 (.clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(rdy_s1), .in_data(in_data), .out_valid(ov_s1),
    .out_ready(out_ready), .out_data(d_s1), .ovf_flag(fl_s1), .ovf_count(cnt_s1),
    .ovf_clear(ovf_clear));
  fxp_convert_pipe #(.N_INT_IN(3), .N_MANT_IN(4), .N_INT_OUT(1), .N_MANT_OUT(2), .N_CH(2),
    .ROUND_MODE(1), .SATURATE(0), .CNT_W(16)) u_s0 (.clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(rdy_s0), .in_data(in_data), .out_valid(ov_s0),
    .out_ready(out_ready), .out_data(d_s0), .ovf_flag(fl_s0), .ovf_count(cnt_s0),
    .ovf_clear(ovf_clear));
  // Q3.4 -> Q5.6 widening
  fxp_convert_pipe #(.N_INT_IN(3), .N_MANT_IN(4), .N_INT_OUT(5), .N_MANT_OUT(6), .N_CH(2),
    .ROUND_MODE(1), .SATURATE(1), .CNT_W(16)) u_w (.clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(rdy_w), .in_data(in_data), .out_valid(ov_w),
    .out_ready(out_ready), .out_data(d_w), .ovf_flag(fl_w), .ovf_count(cnt_w),
    .ovf_clear(ovf_clear));
  // Q3.4 -> Q1.2 with a 2-bit overflow counter
  fxp_convert_pipe #(.N_INT_IN(3), .N_MANT_IN(4), .N_INT_OUT(1), .N_MANT_OUT(2), .N_CH(2),
    .ROUND_MODE(1), .SATURATE(1), .CNT_W(2)) u_c2 (.clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(rdy_c2), .in_data(in_data), .out_valid(ov_c2),
    .out_ready(out_ready), .out_data(d_c2), .ovf_flag(fl_c2), .ovf_count(cnt_c2),
    .ovf_clear(ovf_clear));

  // One beat through an idle pipeline; clr pulses ovf_clear across the S1->S2 edge.
  task automatic send(input logic [7:0] c0, input logic [7:0] c1, input logic clr);
    int n;
    @(negedge clk);
    in_data = {c1, c0}; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; ovf_clear = clr;
    n = 0;
    while (!ov_m1 && n < 8) begin
      @(negedge clk);
      ovf_clear = 1'b0;
      n++;
    end
    ovf_clear = 1'b0;
    n_chk++;
    if (ov_m1 !== 1'b1) begin
      n_fail++; $display("FAIL send_timeout out_valid=%b expected 1", ov_m1);
    end
  endtask

  task automatic clr_pulse();
    @(negedge clk); ovf_clear = 1'b1;
    @(negedge clk); ovf_clear = 1'b0;
  endtask

  task automatic test_reset();
    #1 rstn = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({ov_m0, ov_m1, ov_m2, ov_s1, ov_s0, ov_w, ov_c2} !== 7'b0) begin
      n_fail++; $display("FAIL reset_valid got=%b exp=0", {ov_m0, ov_m1, ov_m2, ov_s1, ov_s0, ov_w, ov_c2});
    end
    n_chk++;
    if ({d_m0, d_m1, d_m2, d_s1, d_s0, d_w, d_c2} !== 84'b0) begin
      n_fail++; $display("FAIL reset_data got=%h exp=0", {d_m0, d_m1, d_m2, d_s1, d_s0, d_w, d_c2});
    end
    n_chk++;
    if ({fl_m0, fl_m1, fl_m2, fl_s1, fl_s0, fl_w, fl_c2} !== 14'b0) begin
      n_fail++; $display("FAIL reset_flag got=%h exp=0", {fl_m0, fl_m1, fl_m2, fl_s1, fl_s0, fl_w, fl_c2});
    end
    n_chk++;
    if ({cnt_m0, cnt_m1, cnt_m2, cnt_s1, cnt_s0, cnt_w, cnt_c2} !== 98'b0) begin
      n_fail++; $display("FAIL reset_count got=%h exp=0", {cnt_m0, cnt_m1, cnt_m2, cnt_s1, cnt_s0, cnt_w, cnt_c2});
    end
    n_chk++;
    if ({rdy_m0, rdy_m1, rdy_m2, rdy_s1, rdy_s0, rdy_w, rdy_c2} !== 7'h7F) begin
      n_fail++; $display("FAIL reset_ready got=%b exp=1111111", {rdy_m0, rdy_m1, rdy_m2, rdy_s1, rdy_s0, rdy_w, rdy_c2});
    end
    @(negedge clk); rstn = 1'b1;
  endtask

  task automatic test_round();
    send(8'd19, 8'd18, 1'b0);
    n_chk++; if (d_m0 !== {6'd4, 6'd4}) begin n_fail++; $display("FAIL round_m0_pos got=%h exp=%h", d_m0, {6'd4, 6'd4}); end
    n_chk++; if (d_m1 !== {6'd5, 6'd5}) begin n_fail++; $display("FAIL round_m1_pos got=%h exp=%h", d_m1, {6'd5, 6'd5}); end
    n_chk++; if (d_m2 !== {6'd4, 6'd5}) begin n_fail++; $display("FAIL round_m2_pos got=%h exp=%h", d_m2, {6'd4, 6'd5}); end
    send(8'hEE, 8'hEF, 1'b0);  // -18, -17
    n_chk++; if (d_m0 !== {6'h3B, 6'h3B}) begin n_fail++; $display("FAIL round_m0_neg got=%h exp=%h", d_m0, {6'h3B, 6'h3B}); end
    n_chk++; if (d_m1 !== {6'h3C, 6'h3C}) begin n_fail++; $display("FAIL round_m1_neg got=%h exp=%h", d_m1, {6'h3C, 6'h3C}); end
    n_chk++; if (d_m2 !== {6'h3C, 6'h3C}) begin n_fail++; $display("FAIL round_m2_neg got=%h exp=%h", d_m2, {6'h3C, 6'h3C}); end
  endtask

  task automatic test_saturation();
    clr_pulse();
    send(8'd64, 8'd0, 1'b0);   // 4.0 into Q1.2
    n_chk++; if (d_s1 !== 8'h07) begin n_fail++; $display("FAIL sat_pos got=%h exp=07", d_s1); end
    n_chk++; if (d_s0 !== 8'h00) begin n_fail++; $display("FAIL wrap_pos got=%h exp=00", d_s0); end
    n_chk++; if (fl_s1 !== 2'b01) begin n_fail++; $display("FAIL sat_flag got=%b exp=01", fl_s1); end
    n_chk++; if (cnt_s1 !== 16'd1) begin n_fail++; $display("FAIL sat_count got=%0d exp=1", cnt_s1); end
    send(8'h80, 8'd0, 1'b0);   // -8.0
    n_chk++; if (d_s1 !== 8'h08) begin n_fail++; $display("FAIL sat_neg got=%h exp=08", d_s1); end
    n_chk++; if (d_s0 !== 8'h00) begin n_fail++; $display("FAIL wrap_neg got=%h exp=00", d_s0); end
    n_chk++; if (cnt_s1 !== 16'd2) begin n_fail++; $display("FAIL sat_count2 got=%0d exp=2", cnt_s1); end
    send(8'd127, 8'h80, 1'b0); // rounding carry on ch0, exact -32 on ch1
    n_chk++; if (d_m1 !== {6'h20, 6'h1F}) begin n_fail++; $display("FAIL round_carry got=%h exp=%h", d_m1, {6'h20, 6'h1F}); end
    n_chk++; if (fl_m1 !== 2'b01) begin n_fail++; $display("FAIL carry_flag got=%b exp=01", fl_m1); end
  endtask

  task automatic test_widen();
    clr_pulse();
    send(8'hDB, 8'h25, 1'b0);  // -37, 37
    n_chk++; if (d_w !== {12'h094, 12'hF6C}) begin n_fail++; $display("FAIL widen_data got=%h exp=%h", d_w, {12'h094, 12'hF6C}); end
    n_chk++; if (fl_w !== 2'b00) begin n_fail++; $display("FAIL widen_flag got=%b exp=00", fl_w); end
    n_chk++; if (cnt_w !== 16'd0) begin n_fail++; $display("FAIL widen_count got=%0d exp=0", cnt_w); end
  endtask

  task automatic test_ovf_clear();
    clr_pulse();
    send(8'd64, 8'd0, 1'b0);
    send(8'd0, 8'd64, 1'b1);
    n_chk++; if (fl_s1 !== 2'b10) begin n_fail++; $display("FAIL clear_coinc_flag got=%b exp=10", fl_s1); end
    n_chk++; if (cnt_s1 !== 16'd1) begin n_fail++; $display("FAIL clear_coinc_count got=%0d exp=1", cnt_s1); end
    clr_pulse();
    for (int i = 0; i < 5; i++) send(8'd64, 8'd64, 1'b0);
    n_chk++; if (cnt_c2 !== 2'd3) begin n_fail++; $display("FAIL count_saturate got=%0d exp=3", cnt_c2); end
    n_chk++; if (fl_c2 !== 2'b11) begin n_fail++; $display("FAIL count_sat_flag got=%b exp=11", fl_c2); end
  endtask

  task automatic test_back_to_back();
    int sent, rcv;
    bit stall;
    logic [11:0] held;
    sent = 0; rcv = 0; stall = 1'b0; held = '0;
    for (int cyc = 0; cyc < 100 && rcv < 8; cyc++) begin
      @(negedge clk);
      if (stall) begin
        n_chk++;
        if (ov_m0 !== 1'b1 || d_m0 !== held) begin
          n_fail++; $display("FAIL bp_hold got=%b/%h exp=1/%h", ov_m0, d_m0, held);
        end
      end
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid  = (sent < 8);
      in_data   = {8'(4 * (sent + 8)), 8'(4 * sent)};
      #1;
      n_chk++;
      if (rdy_m0 !== ((sent - rcv < 2) || out_ready)) begin
        n_fail++; $display("FAIL bp_in_ready got=%b occ=%0d out_ready=%b", rdy_m0, sent - rcv, out_ready);
      end
      if (ov_m0 && out_ready) begin
        n_chk++;
        if (d_m0 !== {6'(rcv + 8), 6'(rcv)}) begin
          n_fail++; $display("FAIL bp_order got=%h exp=%h", d_m0, {6'(rcv + 8), 6'(rcv)});
        end
        rcv++;
      end
      if (in_valid && rdy_m0) sent++;
      stall = ov_m0 && !out_ready;
      held  = d_m0;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    n_chk++; if (rcv != 8) begin n_fail++; $display("FAIL bp_count got=%0d exp=8", rcv); end
  endtask

  task automatic test_reset_inflight();
    clr_pulse();
    @(negedge clk); in_data = {8'd0, 8'd64}; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); in_data = {8'd64, 8'd0};
    @(negedge clk); in_valid = 1'b0;
    n_chk++; if (ov_s1 !== 1'b1 || fl_s1 !== 2'b01) begin n_fail++; $display("FAIL rst_pre got=%b/%b exp=1/01", ov_s1, fl_s1); end
    #1 rstn = 1'b0;
    #1;
    n_chk++; if (ov_s1 !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid got=%b exp=0", ov_s1); end
    n_chk++; if (fl_s1 !== 2'b00) begin n_fail++; $display("FAIL rst_async_flag got=%b exp=00", fl_s1); end
    n_chk++; if (cnt_s1 !== 16'd0) begin n_fail++; $display("FAIL rst_async_count got=%0d exp=0", cnt_s1); end
    n_chk++; if (d_s1 !== 8'h00) begin n_fail++; $display("FAIL rst_async_data got=%h exp=00", d_s1); end
    @(negedge clk); rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_chk++;
      if (ov_s1 !== 1'b0 || ov_m1 !== 1'b0) begin
        n_fail++; $display("FAIL rst_stale cycle=%0d got=%b%b exp=00", i, ov_s1, ov_m1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round();
    test_saturation();
    test_widen();
    test_ovf_clear();
    test_back_to_back();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
